instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory-side and CPU-side handshake signals.
// master: the fetch unit itself. slave: the memory + CPU environment.
interface instr_fetch_unit_if;
  // instruction memory request / response
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  // CPU side
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output instr_valid, instruction, instr_pc,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  instr_valid, instruction, instr_pc,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches under a credit limit, buffers
// returned words in a small FIFO with their PCs, and restarts on redirect,
// discarding responses to requests issued before the redirect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | normal operation; requests issued while credits remain
// S_FLUSH | after a redirect, draining stale responses; no new requests
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic {S_FETCH, S_FLUSH} state_t;

  localparam logic [2:0] DEPTH_L  = 3'(DEPTH);
  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

  state_t      r_state;
  logic        r_started;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_rsp_pc;
  logic [2:0]  r_outstanding;
  logic [2:0]  r_stale;
  logic [2:0]  r_count;
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [31:0] r_buf_data [4];
  logic [31:0] r_buf_pc   [4];

  logic        w_credit;
  logic        w_req_valid;
  logic        w_req_hs;
  logic        w_instr_valid;
  logic        w_instr_hs;
  logic        w_rsp_live;
  logic        w_rsp_keep;
  logic        w_stale_drop;
  logic [2:0]  w_out_after;
  logic [2:0]  w_stale_next;
  logic [31:0] w_redirect_tgt;
  logic        w_unused_pc_bits;

  // Wrap a buffer pointer at DEPTH entries (DEPTH need not be a power of 2).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Request and handshake decode; the request side depends only on registers.
  always_comb begin
    w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < {1'b0, DEPTH_L};
    w_req_valid    = r_started && (r_state == S_FETCH) && w_credit;
    w_req_hs       = w_req_valid && bus.mem_req_ready;
    w_instr_valid  = (r_count != 3'd0);
    w_instr_hs     = w_instr_valid && bus.instr_ready;
    // A response is only genuine if it answers an outstanding request; a
    // pulse with nothing outstanding is a protocol error and is ignored.
    w_rsp_live     = bus.mem_rsp_valid && (r_state == S_FETCH) && (r_outstanding != 3'd0);
    w_rsp_keep     = w_rsp_live && !bus.redirect_valid;
    w_stale_drop   = bus.mem_rsp_valid && (r_state == S_FLUSH) && (r_stale != 3'd0);
    // Outstanding after this cycle's handshakes; on redirect this becomes the
    // stale count, including a request accepted in the redirect cycle.
    w_out_after    = r_outstanding + {2'b00, w_req_hs} - {2'b00, w_rsp_live};
    w_stale_next   = r_stale - {2'b00, w_stale_drop};
    w_redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
  end

  assign w_unused_pc_bits = ^bus.redirect_pc[1:0];

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign bus.instr_valid   = w_instr_valid;
  assign bus.instruction   = r_buf_data[r_rd_ptr];
  assign bus.instr_pc      = r_buf_pc[r_rd_ptr];

  // Fetch/flush FSM with PC and outstanding/stale bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_started     <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= 3'd0;
      r_stale       <= 3'd0;
    end else begin
      // Holds off requests until the first edge after reset release.
      r_started <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (bus.redirect_valid) begin
            r_fetch_pc    <= w_redirect_tgt;
            r_rsp_pc      <= w_redirect_tgt;
            r_outstanding <= 3'd0;
            r_stale       <= w_out_after;
            r_state       <= (w_out_after != 3'd0) ? S_FLUSH : S_FETCH;
          end else begin
            if (w_req_hs)   r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + 32'd4;
            r_outstanding <= w_out_after;
          end
        end
        S_FLUSH: begin
          r_stale <= w_stale_next;
          if (bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_tgt;
            r_rsp_pc   <= w_redirect_tgt;
          end
          if (w_stale_next == 3'd0) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Buffer occupancy and pointers; a redirect empties the buffer after any
  // same-cycle pop has been taken by the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= 3'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else if (bus.redirect_valid) begin
      r_count  <= 3'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      if (w_rsp_keep) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_instr_hs) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + {2'b00, w_rsp_keep} - {2'b00, w_instr_hs};
    end
  end

  // Buffer storage: each kept response is stored with the PC it answers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_buf_data[i] <= 32'd0;
        r_buf_pc[i]   <= 32'd0;
      end
    end else if (w_rsp_keep) begin
      r_buf_data[r_wr_ptr] <= bus.mem_rsp_data;
      r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory model with random latency/stall, a
// CPU model with random backpressure and redirects, and scoreboards for the
// request address stream and the retired instruction stream.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic [31:0] req_exp;
  logic [31:0] redir_tgt;
  logic [31:0] prev_addr;
  int          ready_mode, instr_mode, lat_min, lat_max;
  int          req_count, n_retired, flush_left, base;
  bit          inject_err, flush_exp, pending_redir, prev_stall, prev_redir;

  always @(posedge clk) cyc++;

  // Memory content: an arbitrary but fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: in-order responses after 1+lat cycles, random ready.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!reset) begin
        mem_q.delete();
        bus.mem_rsp_valid = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
        if (flush_left > 0) flush_left--;
      end else if (inject_err) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
        inject_err = 1'b0;
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
      end
      case (ready_mode)
        0:       bus.mem_req_ready = 1'b0;
        1:       bus.mem_req_ready = 1'b1;
        default: bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (reset && bus.mem_req_valid && bus.mem_req_ready) begin
        check("req_addr", bus.mem_req_addr, req_exp);
        req_exp = req_exp + 32'd4;
        mem_q.push_back(mreq_t'{bus.mem_req_addr, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
        req_count++;
      end
    end
  end

  // Monitor: retired instructions against the expected stream, plus
  // request-side rules (no request while flushing, stable while stalled).
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL instr_unexpected actual_pc=%h expected=none", bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", bus.instr_pc, e);
            check("instruction", bus.instruction, mem_word(e));
            n_retired++;
          end
        end
        if (flush_exp) check("flush_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
        if (prev_stall && !prev_redir) begin
          check("req_hold_valid", {31'd0, bus.mem_req_valid}, 32'd1);
          check("req_hold_addr", bus.mem_req_addr, prev_addr);
        end
        prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
        prev_addr  = bus.mem_req_addr;
        prev_redir = bus.redirect_valid;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // One clock of stimulus: applies redirect bookkeeping, refills the stream.
  task automatic step();
    @(posedge clk); #1;
    if (pending_redir) begin
      exp_q.delete();
      next_pc       = {redir_tgt[31:2], 2'b00};
      req_exp       = next_pc;
      flush_left    = mem_q.size();
      flush_exp     = (flush_left > 0);
      pending_redir = 1'b0;
    end else if (flush_left == 0) begin
      flush_exp = 1'b0;
    end
    bus.redirect_valid = 1'b0;
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
    case (instr_mode)
      0:       bus.instr_ready = 1'b0;
      1:       bus.instr_ready = 1'b1;
      default: bus.instr_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    redir_tgt          = t;
    pending_redir      = 1'b1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    next_pc            = RST_PC;
    req_exp            = RST_PC;
    flush_left         = 0;
    flush_exp          = 1'b0;
    pending_redir      = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'd0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    ready_mode = 0; instr_mode = 0; lat_min = 0; lat_max = 0;
    req_count = 0; n_retired = 0; inject_err = 1'b0;
    prev_stall = 1'b0; prev_redir = 1'b0; prev_addr = 32'd0;
    clear_model();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instruction", bus.instruction, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_req_addr", bus.mem_req_addr, RST_PC);

    // Release mid-cycle; no request before the first edge; a stray response
    // arrives with nothing outstanding and must be ignored.
    inject_err = 1'b1;
    reset = 1'b1;
    #1 check("req_before_edge", {31'd0, bus.mem_req_valid}, 32'd0);

    // Memory stall: request held at RESET_PC for 5 cycles
    repeat (5) begin
      step();
      @(negedge clk);
      check("stall_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("stall_addr", bus.mem_req_addr, RST_PC);
    end

    // CPU backpressure: only DEPTH requests issued, head held at pc 0
    ready_mode = 1; instr_mode = 0; req_count = 0;
    repeat (8) step();
    @(negedge clk);
    check("bp_req_count", req_count, 32'd2);
    check("bp_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("bp_head_pc", bus.instr_pc, RST_PC);
    instr_mode = 1; n_retired = 0;
    repeat (3) step();
    @(negedge clk);
    check("bp_release_retired", n_retired, 32'd2);

    // Streaming
    base = n_retired;
    repeat (20) step();
    @(negedge clk);
    check("stream_progress", {31'd0, (n_retired - base) >= 8}, 32'd1);

    // Redirect with two outstanding requests
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_q.size() >= 2) break;
    end
    redirect(32'h0000_0100);
    base = n_retired;
    repeat (20) step();
    @(negedge clk);
    check("redir100_progress", {31'd0, n_retired > base}, 32'd1);

    // Unaligned redirect while streaming with a 1-cycle memory
    lat_min = 0; lat_max = 0;
    repeat (10) step();
    redirect(32'h0000_0203);
    base = n_retired;
    repeat (12) step();
    @(negedge clk);
    check("redir203_progress", {31'd0, n_retired > base}, 32'd1);

    // Reset mid-stream with a full buffer and requests in flight
    instr_mode = 0; lat_min = 2; lat_max = 2;
    repeat (10) step();
    @(negedge clk);
    check("pre_reset_full", {31'd0, bus.instr_valid}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midrst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("midrst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("midrst_req_addr", bus.mem_req_addr, RST_PC);
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    instr_mode = 1; lat_min = 0; lat_max = 0;
    base = n_retired;
    repeat (10) step();
    @(negedge clk);
    check("post_reset_progress", {31'd0, n_retired > base}, 32'd1);

    // Random traffic with random redirects, including near address wrap
    ready_mode = 2; instr_mode = 2; lat_min = 0; lat_max = 3;
    base = n_retired;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0)
          redirect(32'hFFFF_FFE0 | ($urandom & 32'h1F));
        else
          redirect($urandom);
      end
    end
    @(negedge clk);
    check("random_progress", {31'd0, (n_retired - base) >= 300}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
